fp_divsqrt_pool_ctrl: RTL and testbench

Allocation and lifetime controller for a pool of `NUM_UNITS` fixed-latency FP32 divide/sqrt datapaths, sitting between the FP issue stage and the datapaths. Any free unit is granted to an acquiring instruction, with no fixed lane-to-unit binding. The block tracks each unit through reserve, compute and result-hold, counts mode-dependent latency internally, and selectively frees units whose owning instruction is squashed by an active-list range flush.

---
 rtl/fp_divsqrt_pool_ctrl.sv | 150 +++++++++++++++
 tb/tb_fp_divsqrt_pool_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_divsqrt_pool_ctrl.sv
// Allocation and lifetime tracking for a pool of FP32 div/sqrt datapaths.
// Ports: acq_* grant, req_* start, rel_* release, flush_* squash, status out.
module fp_divsqrt_pool_ctrl #(
  parameter int NUM_UNITS    = 2,
  parameter int AL_PTR_WIDTH = 6,
  parameter int LAT_DIV      = 12,
  parameter int LAT_SQRT     = 14,
  parameter int CNT_WIDTH    =
    $clog2((LAT_DIV > LAT_SQRT ? LAT_DIV : LAT_SQRT) + 1),
  parameter int ID_WIDTH     =
    (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    acq_valid,
  input  logic [AL_PTR_WIDTH-1:0] acq_al_ptr,
  output logic                    acq_grant,
  output logic [ID_WIDTH-1:0]     acq_unit_id,
  input  logic                    req_valid,
  input  logic [ID_WIDTH-1:0]     req_unit_id,
  input  logic                    req_is_div,
  output logic [NUM_UNITS-1:0]    unit_start,
  output logic [NUM_UNITS-1:0]    unit_kill,
  input  logic                    rel_valid,
  input  logic [ID_WIDTH-1:0]     rel_unit_id,
  output logic [NUM_UNITS-1:0]    busy,
  output logic [NUM_UNITS-1:0]    reserved,
  output logic [NUM_UNITS-1:0]    done,
  output logic [ID_WIDTH:0]       free_count,
  input  logic                    flush_valid,
  input  logic                    flush_all,
  input  logic [AL_PTR_WIDTH-1:0] flush_head,
  input  logic [AL_PTR_WIDTH-1:0] flush_tail
);

  typedef enum logic [1:0] {
    S_FREE, S_RES, S_PROC, S_WAIT
  } st_e;

  st_e                     st_q  [NUM_UNITS];
  st_e                     st_d  [NUM_UNITS];
  logic [AL_PTR_WIDTH-1:0] own_q [NUM_UNITS];
  logic [AL_PTR_WIDTH-1:0] own_d [NUM_UNITS];
  logic [CNT_WIDTH-1:0]    cnt_q [NUM_UNITS];
  logic [CNT_WIDTH-1:0]    cnt_d [NUM_UNITS];

  logic                    any_free;
  logic [ID_WIDTH-1:0]     gnt_id;
  logic [NUM_UNITS-1:0]    match;

  // Circular active-list range: head inclusive, tail exclusive.
  function automatic logic in_range(
    input logic [AL_PTR_WIDTH-1:0] p,
    input logic [AL_PTR_WIDTH-1:0] h,
    input logic [AL_PTR_WIDTH-1:0] t
  );
    if (h <= t) return (p >= h) && (p < t);
    else        return (p >= h) || (p < t);
  endfunction

  always_comb begin
    any_free = 1'b0;
    gnt_id   = '0;
    // Descending scan so the lowest free index wins.
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (st_q[i] == S_FREE) begin
        any_free = 1'b1;
        gnt_id   = ID_WIDTH'(i);
      end
    end
    acq_grant   = rst_n & acq_valid & any_free & ~flush_valid;
    acq_unit_id = gnt_id;
  end

  always_comb begin
    unit_start = '0;
    unit_kill  = '0;
    match      = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      st_d[i]  = st_q[i];
      own_d[i] = own_q[i];
      cnt_d[i] = cnt_q[i];
      match[i] = flush_valid && (st_q[i] != S_FREE) &&
                 (flush_all ||
                  in_range(own_q[i], flush_head, flush_tail));
      unique case (st_q[i])
        S_FREE: begin
          if (acq_grant && gnt_id == ID_WIDTH'(i)) begin
            st_d[i]  = S_RES;
            own_d[i] = acq_al_ptr;
          end
        end
        S_RES: begin
          if (req_valid && req_unit_id == ID_WIDTH'(i)) begin
            st_d[i]       = S_PROC;
            unit_start[i] = 1'b1;
            cnt_d[i]      = req_is_div ? CNT_WIDTH'(LAT_DIV - 1)
                                       : CNT_WIDTH'(LAT_SQRT - 1);
          end
        end
        S_PROC: begin
          cnt_d[i] = cnt_q[i] - 1'b1;
          if (cnt_q[i] == CNT_WIDTH'(1)) st_d[i] = S_WAIT;
        end
        S_WAIT: begin
          if (rel_valid && rel_unit_id == ID_WIDTH'(i))
            st_d[i] = S_FREE;
        end
        default: st_d[i] = S_FREE;
      endcase
      // Squash wins over every other transition this cycle.
      if (match[i]) begin
        st_d[i]       = S_FREE;
        cnt_d[i]      = cnt_q[i];
        unit_start[i] = 1'b0;
        unit_kill[i]  = (st_q[i] == S_RES) || (st_q[i] == S_PROC);
      end
    end
  end

  always_comb begin
    free_count = '0;
    busy       = '0;
    reserved   = '0;
    done       = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      free_count  = free_count + (ID_WIDTH + 1)'(st_q[i] == S_FREE);
      busy[i]     = (st_q[i] == S_PROC);
      reserved[i] = (st_q[i] == S_RES);
      done[i]     = (st_q[i] == S_WAIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        st_q[i]  <= S_FREE;
        own_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        st_q[i]  <= st_d[i];
        own_q[i] <= own_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fp_divsqrt_pool_ctrl.sv
// Bench for fp_divsqrt_pool_ctrl: vector table for flush ranges,
// scoreboard on done timing, hand sequences for multi-cycle cases.
module tb_fp_divsqrt_pool_ctrl;
  localparam int N  = 2;
  localparam int AW = 6;
  localparam int LD = 12;
  localparam int LS = 14;
  localparam int IW = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          acq_valid;
  logic [AW-1:0] acq_al_ptr;
  logic          acq_grant;
  logic [IW-1:0] acq_unit_id;
  logic          req_valid;
  logic [IW-1:0] req_unit_id;
  logic          req_is_div;
  logic [N-1:0]  unit_start;
  logic [N-1:0]  unit_kill;
  logic          rel_valid;
  logic [IW-1:0] rel_unit_id;
  logic [N-1:0]  busy;
  logic [N-1:0]  reserved;
  logic [N-1:0]  done;
  logic [IW:0]   free_count;
  logic          flush_valid;
  logic          flush_all;
  logic [AW-1:0] flush_head;
  logic [AW-1:0] flush_tail;

  fp_divsqrt_pool_ctrl #(
    .NUM_UNITS(N), .AL_PTR_WIDTH(AW),
    .LAT_DIV(LD), .LAT_SQRT(LS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .acq_valid(acq_valid), .acq_al_ptr(acq_al_ptr),
    .acq_grant(acq_grant), .acq_unit_id(acq_unit_id),
    .req_valid(req_valid), .req_unit_id(req_unit_id),
    .req_is_div(req_is_div),
    .unit_start(unit_start), .unit_kill(unit_kill),
    .rel_valid(rel_valid), .rel_unit_id(rel_unit_id),
    .busy(busy), .reserved(reserved), .done(done),
    .free_count(free_count),
    .flush_valid(flush_valid), .flush_all(flush_all),
    .flush_head(flush_head), .flush_tail(flush_tail)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unit;
    int due;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [AW-1:0] own;
    logic [AW-1:0] hd;
    logic [AW-1:0] tl;
    logic          all;
    logic          kill;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic idle();
    acq_valid   = 1'b0;
    acq_al_ptr  = '0;
    req_valid   = 1'b0;
    req_unit_id = '0;
    req_is_div  = 1'b0;
    rel_valid   = 1'b0;
    rel_unit_id = '0;
    flush_valid = 1'b0;
    flush_all   = 1'b0;
    flush_head  = '0;
    flush_tail  = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic acquire(input int ptr, input int id);
    acq_valid  = 1'b1;
    acq_al_ptr = AW'(ptr);
    #1;
    chk("acq_grant", int'(acq_grant), 1);
    chk("acq_unit_id", int'(acq_unit_id), id);
    tick();
    acq_valid = 1'b0;
  endtask

  task automatic request(input int u, input bit div);
    req_valid   = 1'b1;
    req_unit_id = IW'(u);
    req_is_div  = div;
    #1;
    chk("unit_start", int'(unit_start), 1 << u);
    sbq.push_back('{u, cyc + (div ? LD : LS)});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drop_unit(input int u);
    for (int k = sbq.size() - 1; k >= 0; k--)
      if (sbq[k].unit == u) sbq.delete(k);
  endtask

  task automatic wait_done(input logic [N-1:0] m);
    int n;
    n = 0;
    while ((done & m) != m && n < 40) begin
      tick();
      n++;
    end
    #1;
    chk("wait_done", int'(done & m), int'(m));
  endtask

  // Scoreboard: busy while outstanding, done must rise exactly on due cycle.
  logic [N-1:0] prv = '0;
  always @(posedge clk) begin
    #1;
    foreach (sbq[k])
      if (cyc < sbq[k].due)
        chk("busy_hold", int'(busy[sbq[k].unit]), 1);
    for (int u = 0; u < N; u++) begin
      if (done[u] && !prv[u]) begin
        int idx;
        idx = -1;
        foreach (sbq[k])
          if (idx < 0 && sbq[k].unit == u) idx = k;
        if (idx < 0) begin
          chk("done_unexpected", u, -1);
        end else begin
          chk("done_cycle", cyc, sbq[idx].due);
          sbq.delete(idx);
        end
      end
    end
    prv = done;
  end

  initial begin
    vt[0]  = '{6'd5,  6'd3,  6'd8,  1'b0, 1'b1};
    vt[1]  = '{6'd8,  6'd3,  6'd8,  1'b0, 1'b0};
    vt[2]  = '{6'd3,  6'd3,  6'd8,  1'b0, 1'b1};
    vt[3]  = '{6'd2,  6'd3,  6'd8,  1'b0, 1'b0};
    vt[4]  = '{6'd62, 6'd60, 6'd3,  1'b0, 1'b1};
    vt[5]  = '{6'd2,  6'd60, 6'd3,  1'b0, 1'b1};
    vt[6]  = '{6'd3,  6'd60, 6'd3,  1'b0, 1'b0};
    vt[7]  = '{6'd30, 6'd60, 6'd3,  1'b0, 1'b0};
    vt[8]  = '{6'd7,  6'd7,  6'd7,  1'b0, 1'b0};
    vt[9]  = '{6'd7,  6'd7,  6'd7,  1'b1, 1'b1};
    vt[10] = '{6'd0,  6'd60, 6'd0,  1'b0, 1'b0};
    vt[11] = '{6'd63, 6'd60, 6'd0,  1'b0, 1'b1};

    idle();
    rst_n = 1'b0;
    acq_valid = 1'b1;
    repeat (2) tick();
    #1;
    chk("rst_free_count", int'(free_count), 2);
    chk("rst_busy", int'(busy), 0);
    chk("rst_reserved", int'(reserved), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_start", int'(unit_start), 0);
    chk("rst_kill", int'(unit_kill), 0);
    chk("rst_grant", int'(acq_grant), 0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    acquire(5, 0);
    #1;
    chk("reserved_after_acq", int'(reserved), 1);
    chk("free_after_acq", int'(free_count), 1);
    acquire(7, 1);
    acq_valid = 1'b1;
    acq_al_ptr = 6'd9;
    #1;
    chk("exhaust_grant", int'(acq_grant), 0);
    tick();
    acq_valid = 1'b0;
    #1;
    chk("exhaust_free", int'(free_count), 0);
    chk("exhaust_reserved", int'(reserved), 3);

    request(0, 1'b1);
    #1;
    chk("busy_div", int'(busy), 1);
    request(1, 1'b0);
    rel_valid   = 1'b1;
    rel_unit_id = 1'b0;
    #1;
    chk("bad_rel_start", int'(unit_start), 0);
    chk("bad_rel_kill", int'(unit_kill), 0);
    tick();
    rel_valid = 1'b0;
    #1;
    chk("bad_rel_busy", int'(busy), 3);
    chk("bad_rel_done", int'(done), 0);
    wait_done(2'b11);

    rel_valid   = 1'b1;
    rel_unit_id = 1'b1;
    acq_valid   = 1'b1;
    acq_al_ptr  = 6'd9;
    #1;
    chk("rel_same_cycle_grant", int'(acq_grant), 0);
    tick();
    rel_valid   = 1'b0;
    req_valid   = 1'b1;
    req_unit_id = 1'b1;
    req_is_div  = 1'b1;
    #1;
    chk("reuse_grant", int'(acq_grant), 1);
    chk("reuse_id", int'(acq_unit_id), 1);
    chk("req_free_start", int'(unit_start), 0);
    tick();
    idle();
    #1;
    chk("reuse_reserved", int'(reserved), 2);
    chk("req_free_busy", int'(busy), 0);
    chk("reuse_done", int'(done), 1);

    flush_valid = 1'b1;
    flush_all   = 1'b1;
    #1;
    chk("flush_all_kill", int'(unit_kill), 2);
    tick();
    idle();
    #1;
    chk("flush_all_free", int'(free_count), 2);
    chk("flush_all_done", int'(done), 0);

    acquire(62, 0);
    acquire(10, 1);
    request(1, 1'b0);
    wait_done(2'b10);
    request(0, 1'b1);
    flush_valid = 1'b1;
    flush_head  = 6'd60;
    flush_tail  = 6'd3;
    #1;
    chk("wrap_kill", int'(unit_kill), 1);
    drop_unit(0);
    tick();
    idle();
    #1;
    chk("wrap_free", int'(free_count), 1);
    chk("wrap_busy", int'(busy), 0);
    chk("wrap_done", int'(done), 2);

    rel_valid   = 1'b1;
    rel_unit_id = 1'b1;
    tick();
    rel_valid = 1'b0;
    acquire(20, 0);
    flush_valid = 1'b1;
    flush_all   = 1'b1;
    req_valid   = 1'b1;
    req_unit_id = 1'b0;
    req_is_div  = 1'b1;
    acq_valid   = 1'b1;
    acq_al_ptr  = 6'd21;
    #1;
    chk("prio_start", int'(unit_start), 0);
    chk("prio_kill", int'(unit_kill), 1);
    chk("prio_grant", int'(acq_grant), 0);
    tick();
    idle();
    #1;
    chk("prio_free", int'(free_count), 2);
    chk("prio_reserved", int'(reserved), 0);

    for (int v = 0; v < 12; v++) begin
      acquire(int'(vt[v].own), 0);
      flush_valid = 1'b1;
      flush_all   = vt[v].all;
      flush_head  = vt[v].hd;
      flush_tail  = vt[v].tl;
      #1;
      chk($sformatf("vec%0d_kill", v), int'(unit_kill),
          int'(vt[v].kill));
      tick();
      idle();
      #1;
      chk($sformatf("vec%0d_free", v), int'(free_count),
          vt[v].kill ? 2 : 1);
      flush_valid = 1'b1;
      flush_all   = 1'b1;
      tick();
      idle();
    end

    repeat (2) tick();
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
